// File: rtl/nibble_sram_ctrl.sv
// rtl/nibble_sram_ctrl.sv - byte request/response front end for a 4Kx4 asynchronous-read SRAM
// Each byte access becomes a low-nibble then high-nibble phase of WAIT+1 cycles each.
module nibble_sram_ctrl #(
  parameter int ADDR_W = 11,
  parameter int WAIT   = 0
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
  output logic              rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic [ADDR_W:0]   sram_addr,
  output logic [3:0]        sram_din,
  input  logic [3:0]        sram_dout,
  output logic              sram_we_b,
  output logic              sram_e_b
);

  localparam int               CNT_W    = (WAIT > 0) ? $clog2(WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT);

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    RESP
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                txn_we;
  logic [ADDR_W-1:0]   txn_addr;
  logic [3:0]          wdata_hi;
  logic [3:0]          rdata_lo;

  // All SRAM strobes are registered; the SRAM sees them one edge after the state that owns them.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      cnt       <= '0;
      txn_we    <= 1'b0;
      txn_addr  <= '0;
      wdata_hi  <= '0;
      rdata_lo  <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      sram_addr <= '0;
      sram_din  <= '0;
      sram_we_b <= 1'b1;
      sram_e_b  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            txn_we    <= req_we;
            txn_addr  <= req_addr;
            wdata_hi  <= req_wdata[7:4];
            sram_addr <= {req_addr, 1'b0};
            sram_din  <= req_wdata[3:0];
            sram_e_b  <= 1'b0;
            sram_we_b <= ~req_we;
            req_ready <= 1'b0;
            cnt       <= '0;
            state     <= LO;
          end
        end
        LO: begin
          if (cnt == CNT_LAST) begin
            if (!txn_we) rdata_lo <= sram_dout;
            sram_addr <= {txn_addr, 1'b1};
            sram_din  <= wdata_hi;
            cnt       <= '0;
            state     <= HI;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HI: begin
          if (cnt == CNT_LAST) begin
            // rsp_rdata only moves on a completed read so writes leave the last read byte visible
            if (!txn_we) rsp_rdata <= {sram_dout, rdata_lo};
            sram_e_b  <= 1'b1;
            sram_we_b <= 1'b1;
            rsp_valid <= 1'b1;
            cnt       <= '0;
            state     <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_sram_ctrl.sv
// tb/tb_nibble_sram_ctrl.sv - self-checking bench for nibble_sram_ctrl at WAIT=0 and WAIT=2
// Uses a byte-level memory model and a behavioural 4Kx4 SRAM model per instance.
module tb_nibble_sram_ctrl;

  logic        clk;
  logic        rst_b;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [10:0] req_addr  [2];
  logic [7:0]  req_wdata [2];
  logic        rsp_valid [2];
  logic [7:0]  rsp_rdata [2];
  logic [11:0] sram_addr [2];
  logic [3:0]  sram_din  [2];
  logic [3:0]  sram_dout [2];
  logic        sram_we_b [2];
  logic        sram_e_b  [2];

  logic [3:0]  mem   [2][4096];
  logic [7:0]  model [2][2048];
  logic [7:0]  exp_last [2];
  int          checks;
  int          errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    nibble_sram_ctrl #(.ADDR_W(11), .WAIT(2 * g)) u_dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_rdata (rsp_rdata[g]),
      .sram_addr (sram_addr[g]),
      .sram_din  (sram_din[g]),
      .sram_dout (sram_dout[g]),
      .sram_we_b (sram_we_b[g]),
      .sram_e_b  (sram_e_b[g])
    );
  end

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++)
      if (!sram_e_b[g] && !sram_we_b[g]) mem[g][sram_addr[g]] <= sram_din[g];
  end

  always_comb begin
    for (int g = 0; g < 2; g++)
      sram_dout[g] = (!sram_e_b[g] && sram_we_b[g]) ? mem[g][sram_addr[g]] : 4'h0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete transaction on instance g with phase-by-phase and latency checks.
  task automatic do_txn(input int g, input bit we, input logic [10:0] a, input logic [7:0] wd);
    int  w;
    bit  got;
    logic [7:0] exp_rd;
    w      = 2 * g;
    exp_rd = model[g][a];
    @(negedge clk);
    req_valid[g] = 1'b1;
    req_we[g]    = we;
    req_addr[g]  = a;
    req_wdata[g] = wd;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (req_ready[g]) got = 1'b1;
      else @(negedge clk);
    end
    check("ready_wait", got, 1);
    if (!got) begin
      req_valid[g] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[g] = 1'b0;
    for (int n = 0; n <= 2 * w + 1; n++) begin
      check("phase_rsp_valid", rsp_valid[g], 0);
      check("phase_ready", req_ready[g], 0);
      check("phase_e_b", sram_e_b[g], 0);
      check("phase_we_b", sram_we_b[g], !we);
      check("phase_addr", sram_addr[g], {a, (n > w) ? 1'b1 : 1'b0});
      if (we) check("phase_din", sram_din[g], (n > w) ? wd[7:4] : wd[3:0]);
      @(negedge clk);
    end
    check("rsp_valid_latency", rsp_valid[g], 1);
    check("resp_e_b", sram_e_b[g], 1);
    check("resp_we_b", sram_we_b[g], 1);
    if (!we) exp_last[g] = exp_rd;
    check("rsp_rdata", rsp_rdata[g], exp_last[g]);
    @(negedge clk);
    check("rsp_pulse_len", rsp_valid[g], 0);
    check("ready_after", req_ready[g], 1);
    check("rdata_hold", rsp_rdata[g], exp_last[g]);
    if (we) begin
      model[g][a] = wd;
      check("sram_lo", mem[g][{a, 1'b0}], wd[3:0]);
      check("sram_hi", mem[g][{a, 1'b1}], wd[7:4]);
    end
  endtask

  task automatic check_reset_outputs(input int g);
    check("rst_ready", req_ready[g], 1);
    check("rst_rsp_valid", rsp_valid[g], 0);
    check("rst_e_b", sram_e_b[g], 1);
    check("rst_we_b", sram_we_b[g], 1);
    check("rst_rdata", rsp_rdata[g], 0);
  endtask

  // Three requests queued behind a constantly asserted req_valid on the WAIT=0 instance.
  task automatic queued_test();
    logic [10:0] qa [3];
    logic [7:0]  qd [3];
    bit          qw [3];
    int          acc [$];
    int          idx, pulses;
    bit          pend;
    qa[0] = 11'h100; qd[0] = 8'h11; qw[0] = 1'b1;
    qa[1] = 11'h101; qd[1] = 8'h22; qw[1] = 1'b1;
    qa[2] = 11'h100; qd[2] = 8'h00; qw[2] = 1'b0;
    idx = 0; pulses = 0; pend = 1'b0;
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0] = qw[0]; req_addr[0] = qa[0]; req_wdata[0] = qd[0];
    for (int c = 0; c < 40; c++) begin
      if (rsp_valid[0]) begin
        pulses++;
        if (pulses == 3) check("queued_read", rsp_rdata[0], qd[0]);
      end
      if (pend) begin
        idx++;
        if (idx < 3) begin
          req_we[0] = qw[idx]; req_addr[0] = qa[idx]; req_wdata[0] = qd[idx];
        end else begin
          req_valid[0] = 1'b0;
        end
      end
      pend = req_valid[0] && req_ready[0];
      if (pend) acc.push_back(c);
      @(negedge clk);
    end
    check("queued_accepts", acc.size(), 3);
    if (acc.size() == 3) begin
      check("queued_gap0", acc[1] - acc[0], 4);
      check("queued_gap1", acc[2] - acc[1], 4);
    end
    check("queued_pulses", pulses, 3);
    model[0][11'h100] = 8'h11;
    model[0][11'h101] = 8'h22;
    exp_last[0] = 8'h11;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [10:0] pool [8];
    checks = 0;
    errors = 0;
    exp_last[0] = 8'h00;
    exp_last[1] = 8'h00;
    for (int g = 0; g < 2; g++) begin
      req_valid[g] = 1'b0; req_we[g] = 1'b0; req_addr[g] = '0; req_wdata[g] = '0;
    end
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check_reset_outputs(g);
      check("rst_addr", sram_addr[g], 0);
      check("rst_din", sram_din[g], 0);
    end
    rst_b = 1'b1;

    do_txn(0, 1'b1, 11'h123, 8'hA5);
    do_txn(0, 1'b0, 11'h123, 8'h00);
    do_txn(1, 1'b1, 11'h7FF, 8'h3C);
    do_txn(1, 1'b0, 11'h7FF, 8'h00);

    // Asynchronous reset landing between edges while a write is in its LO phase.
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 11'h055; req_wdata[0] = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("pre_rst_e_b", sram_e_b[0], 0);
    #2 rst_b = 1'b0;
    #1;
    exp_last[0] = 8'h00;
    exp_last[1] = 8'h00;
    check_reset_outputs(0);
    check_reset_outputs(1);
    @(negedge clk);
    rst_b = 1'b1;

    // Reset during HI of a write: the low nibble sticks, the high nibble does not.
    do_txn(0, 1'b1, 11'h010, 8'h77);
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 11'h010; req_wdata[0] = 8'hF0;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("hi_addr", sram_addr[0], 12'h021);
    #2 rst_b = 1'b0;
    #1 check("partial_rsp_valid", rsp_valid[0], 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("partial_no_rsp", rsp_valid[0], 0);
    end
    rst_b = 1'b1;
    @(negedge clk);
    check("partial_ready", req_ready[0], 1);
    check("partial_no_rsp_after", rsp_valid[0], 0);
    check("partial_lo", mem[0][12'h020], 4'h0);
    check("partial_hi", mem[0][12'h021], 4'h7);
    model[0][11'h010] = 8'h70;
    exp_last[0] = 8'h00;
    exp_last[1] = 8'h00;
    do_txn(0, 1'b0, 11'h010, 8'h00);

    queued_test();
    do_txn(0, 1'b0, 11'h101, 8'h00);

    pool[0] = 11'h000; pool[1] = 11'h001; pool[2] = 11'h7FF; pool[3] = 11'h400;
    pool[4] = 11'h123; pool[5] = 11'h2AA; pool[6] = 11'h555; pool[7] = 11'h3FF;
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 8; i++) do_txn(g, 1'b1, pool[i], 8'($urandom));
      for (int i = 0; i < 30; i++)
        do_txn(g, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
